// File: rtl/mix_seq_ctrl.sv
// Sequencer for the ratio-sine datapath: divider and s2p run together,
// then the multiplier; the result is held until the consumer takes it.
module mix_seq_ctrl #(
   parameter int DW          = 12,
   parameter int SER_BITS    = 10,
   parameter int MUL_LAT     = 2,
   parameter int DIV_TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     a,
   input  logic [DW-1:0]     b,
   input  logic [DW-1:0]     c,
   output logic              div_en,
   output logic [2*DW+1:0]   div_dividend,
   output logic [DW+1:0]     div_divisor,
   input  logic              div_ok,
   output logic              ser_en,
   output logic              mul_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err,
   output logic [1:0]        err_code,
   output logic              busy
);

   localparam int BW = $clog2(SER_BITS + 1);
   localparam int TW = $clog2(DIV_TIMEOUT + 1);
   localparam int MW = $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {IDLE, RUN, MUL, DONE} state_t;

   state_t        state;
   logic [DW-1:0] a_r, b_r, c_r;
   logic [BW-1:0] bit_cnt;
   logic [TW-1:0] to_cnt;
   logic [MW-1:0] mul_cnt;
   logic          ser_done, div_done;
   logic          ser_last, div_hit, to_hit;
   logic          ser_fin, div_fin;

   assign in_ready     = (state == IDLE);
   assign busy         = (state != IDLE);
   assign div_dividend = {a_r, {(DW+2){1'b0}}};
   assign div_divisor  = {2'b00, a_r} + {2'b00, b_r} + {2'b00, c_r};

   always_comb begin
      ser_last = ser_en && (bit_cnt == BW'(SER_BITS - 1));
      div_hit  = (state == RUN) && !div_done && div_ok;
      to_hit   = !div_done && !div_ok && (to_cnt == TW'(DIV_TIMEOUT - 1));
      ser_fin  = ser_done || ser_last;
      div_fin  = div_done || div_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= '0;
         bit_cnt   <= '0;
         to_cnt    <= '0;
         mul_cnt   <= '0;
         ser_done  <= 1'b0;
         div_done  <= 1'b0;
         div_en    <= 1'b0;
         ser_en    <= 1'b0;
         mul_en    <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  c_r      <= c;
                  bit_cnt  <= '0;
                  to_cnt   <= '0;
                  mul_cnt  <= '0;
                  ser_done <= 1'b0;
                  div_done <= 1'b0;
                  if ((a | b | c) == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     err       <= 1'b1;
                     err_code  <= 2'b01;
                  end else begin
                     state  <= RUN;
                     ser_en <= 1'b1;
                     div_en <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!div_done)
                  to_cnt <= to_cnt + 1'b1;
               if (ser_en) begin
                  if (ser_last) begin
                     ser_en   <= 1'b0;
                     ser_done <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               if (div_hit) begin
                  div_en   <= 1'b0;
                  div_done <= 1'b1;
               end
               // a div_ok on the timeout cycle clears to_hit, so it wins
               if (ser_fin && div_fin) begin
                  state   <= MUL;
                  mul_en  <= 1'b1;
                  mul_cnt <= '0;
               end else if (to_hit) begin
                  state     <= DONE;
                  ser_en    <= 1'b0;
                  div_en    <= 1'b0;
                  out_valid <= 1'b1;
                  err       <= 1'b1;
                  err_code  <= 2'b10;
               end
            end
            MUL: begin
               if (mul_cnt == MW'(MUL_LAT - 1)) begin
                  state     <= DONE;
                  mul_en    <= 1'b0;
                  out_valid <= 1'b1;
                  err       <= 1'b0;
                  err_code  <= 2'b00;
               end else begin
                  mul_cnt <= mul_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  err       <= 1'b0;
                  err_code  <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Scoreboard bench for mix_seq_ctrl: directed transactions push expected
// results; a monitor tracks enable windows and compares on the handshake.
module tb_mix_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] a = '0, b = '0, c = '0;
   logic        div_en;
   logic [25:0] div_dividend;
   logic [13:0] div_divisor;
   logic        div_ok = 1'b0;
   logic        ser_en, mul_en, out_valid;
   logic        out_ready = 1'b0;
   logic        err;
   logic [1:0]  err_code;
   logic        busy;

   mix_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .div_en(div_en), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_ok(div_ok), .ser_en(ser_en),
      .mul_en(mul_en), .out_valid(out_valid), .out_ready(out_ready),
      .err(err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [1:0]  code;
      logic [13:0] dsr;
      logic [25:0] dnd;
      int          lat;
      int          ser_n;
      int          div_n;
      int          mul_n;
      int          mul_s;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [11:0] nxt_a, nxt_b, nxt_c;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // monitor samples 1 time unit after each rising edge
   int cyc = 0, t0 = 0;
   bit active = 0, p_ready = 1, p_ov = 0;
   int ov_t, ser_n, div_n, mul_n, mul_s;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         active  = 0;
         p_ov    = 0;
         p_ready = 1;
      end else begin
         if (active && p_ov && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("divisor", 32'(div_divisor), 32'(e.dsr));
               chk("dividend", 32'(div_dividend), 32'(e.dnd));
               chk("out_latency", ov_t, e.lat);
               chk("ser_cycles", ser_n, e.ser_n);
               chk("div_cycles", div_n, e.div_n);
               chk("mul_cycles", mul_n, e.mul_n);
               chk("mul_start", mul_s, e.mul_s);
            end
            active = 0;
         end
         if (p_ready && in_valid) begin
            active = 1;
            t0 = cyc;
            ov_t = 0; ser_n = 0; div_n = 0; mul_n = 0; mul_s = 0;
         end
         if (active) begin
            int rel;
            rel = cyc - t0 + 1;
            if (ser_en) ser_n++;
            if (div_en) div_n++;
            if (mul_en) begin
               mul_n++;
               if (mul_s == 0) mul_s = rel;
            end
            if (out_valid) begin
               if (ov_t == 0) ov_t = rel;
               if (q.size() == 0) begin
                  chk("valid_without_expect", 1, 0);
               end else begin
                  chk("err_held", 32'(err), 32'(q[0].err));
                  chk("err_code_held", 32'(err_code), 32'(q[0].code));
               end
            end
         end
         p_ready = in_ready;
         p_ov    = out_valid;
      end
      cyc++;
   end

   // caller is parked at a falling edge on entry and on return
   task automatic run_txn(input logic [11:0] ta, input logic [11:0] tb_,
                          input logic [11:0] tc, input int ok_at,
                          input int rdly, input exp_t e, input bit bp);
      int  w;
      bit  done;
      w = 0;
      done = 0;
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      if (!in_ready) chk("ready_wait", 0, 1);
      a = ta; b = tb_; c = tc;
      in_valid = 1'b1;
      q.push_back(e);
      @(posedge clk);
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         div_ok = (k == ok_at);
         if (out_valid) begin
            if (bp) begin
               chk("ready_low_in_done", 32'(in_ready), 0);
               a = nxt_a; b = nxt_b; c = nxt_c;
               in_valid = 1'b1;
            end
            if (w >= rdly) out_ready = 1'b1;
            w++;
         end
         @(posedge clk);
         if (out_ready) begin
            done = 1;
            break;
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      div_ok = 1'b0;
      if (!done) chk("txn_timeout", 0, 1);
      if (bp) chk("ready_after_handshake", 32'(in_ready), 1);
   endtask

   function automatic exp_t mk(input logic e, input logic [1:0] cd,
                               input logic [13:0] dsr, input logic [25:0] dnd,
                               input int lat, input int sn, input int dn,
                               input int mn, input int ms);
      exp_t r;
      r.err = e; r.code = cd; r.dsr = dsr; r.dnd = dnd;
      r.lat = lat; r.ser_n = sn; r.div_n = dn; r.mul_n = mn; r.mul_s = ms;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_enables", 32'({div_en, ser_en, mul_en}), 0);
      chk("rst_out", 32'({out_valid, err, err_code}), 0);
      chk("rst_divisor", 32'(div_divisor), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_no_pulse", 32'({out_valid, div_en, ser_en, mul_en}), 0);

      div_ok = 1'b1;
      @(negedge clk);
      div_ok = 1'b0;
      chk("idle_div_ok_ignored", 32'({busy, div_en}), 0);

      // nominal
      run_txn(12'h100, 12'h100, 12'h200, 20, 0,
              mk(0, 2'b00, 14'h400, 26'h0400000, 23, 10, 20, 2, 21), 0);
      // zero operands
      run_txn(12'h000, 12'h000, 12'h000, 0, 0,
              mk(1, 2'b01, 14'h000, 26'h0000000, 1, 0, 0, 0, 0), 0);
      // divider timeout
      run_txn(12'h001, 12'h000, 12'h000, 0, 0,
              mk(1, 2'b10, 14'h001, 26'h0004000, 33, 10, 32, 0, 0), 0);
      // early divider
      run_txn(12'h003, 12'h005, 12'h007, 3, 0,
              mk(0, 2'b00, 14'h00F, 26'h000C000, 13, 10, 3, 2, 11), 0);
      // backpressure with a new set waiting
      nxt_a = 12'h123; nxt_b = 12'h045; nxt_c = 12'h006;
      run_txn(12'hFFF, 12'hFFF, 12'hFFF, 12, 5,
              mk(0, 2'b00, 14'h2FFD, 26'h3FFC000, 15, 10, 12, 2, 13), 1);
      run_txn(nxt_a, nxt_b, nxt_c, 20, 0,
              mk(0, 2'b00, 14'h016E, 26'h048C000, 23, 10, 20, 2, 21), 0);

      // reset mid-RUN
      a = 12'h100; b = 12'h100; c = 12'h200;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_reset_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_enables", 32'({div_en, ser_en, mul_en}), 0);
      chk("async_out_valid", 32'(out_valid), 0);
      chk("async_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_quiet", 32'({out_valid, err, busy}), 0);
      run_txn(12'h100, 12'h100, 12'h200, 20, 0,
              mk(0, 2'b00, 14'h400, 26'h0400000, 23, 10, 20, 2, 21), 0);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mix_seq_ctrl.md
Name: mix_seq_ctrl

Overview:
Sequencer for the ratio–sine datapath (divider → sin LUT → multiplier). It accepts one operand set {a,b,c} per transaction over a valid/ready handshake and captures the operands. It drives the divider and the serial-to-parallel loader concurrently, then runs the multiplier for a fixed latency. It presents a result-valid handshake with error reporting, and replaces the free-running enables currently derived from a||b||c.

Parameters:
DW, 12, operand width of a/b/c.
SER_BITS, 10, serial phase bits loaded through s2p per transaction.
MUL_LAT, 2, multiplier latency in cycles.
DIV_TIMEOUT, 32, maximum RUN cycles to wait for div_ok.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand set valid.
in_ready  out  1  controller can accept; equals (state==IDLE).
a, b, c  in  DW each  operands, sampled on accept.
div_en  out  1  divider enable.
div_dividend  out  2*DW+2  {a_r, (DW+2) zeros}.
div_divisor  out  DW+2  a_r+b_r+c_r, zero-extended, no truncation.
div_ok  in  1  divider result valid pulse/level.
ser_en  out  1  s2p shift enable; the datapath shifts e in each ser_en cycle.
mul_en  out  1  multiplier enable.
out_valid  out  1  result y valid in datapath.
out_ready  in  1  consumer accepts result.
err  out  1  transaction failed; datapath forces y=0.
err_code  out  2  00 ok, 01 zero divisor, 10 divider timeout.
busy  out  1  state!=IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_r/b_r/c_r, counters, div_en, ser_en, mul_en, out_valid, err, err_code, busy and dividend/divisor = 0; in_ready=1.
- States: IDLE, RUN, MUL, DONE.
- IDLE: accept on the edge where in_valid&&in_ready is high (T0); capture a,b,c.
  - If a|b|c==0: next state DONE, err=1, err_code=01.
  - Otherwise: next state RUN and clear counters.
- RUN (from T1):
  - ser_en is high for exactly SER_BITS cycles (bit counter 0..SER_BITS-1), then low; ser_done is set.
  - div_en is high from T1 until the cycle after div_ok is sampled high; div_done is set.
  - The timeout counter increments every RUN cycle while !div_done.
  - Exit when ser_done&&div_done (both flags may set on the same edge) → MUL.
  - If the counter reaches DIV_TIMEOUT with div_ok still low → DONE, err=1, err_code=10, ser_en and div_en forced low.
  - If div_ok arrives on the same cycle the timeout is reached, div_ok wins.
- MUL: mul_en=1 for exactly MUL_LAT cycles, then DONE with err=0, err_code=00.
- DONE: out_valid=1 and held, with err/err_code stable, until out_ready=1.
  - That edge → IDLE, out_valid=0, err cleared.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- div_ok outside RUN or after div_done: ignored.
- in_valid while busy: ignored; the operands are not re-sampled.
- Registered outputs; no combinational path from in_valid/out_ready/div_ok to any output except in_ready (state decode).
- rst_n low mid-transaction aborts immediately. No output pulse is issued on reset release.

Test Plan:
1. Nominal: a=12'h100, b=12'h100, c=12'h200, div_ok one-cycle at T20.
   -> div_divisor=14'h400, div_dividend=26'h0400000.
   -> ser_en high T1–T10; div_en high T1–T20.
   -> mul_en high T21–T22; out_valid=1 at T23, err=0.
2. Zero operands: a=b=c=0.
   -> out_valid=1 at T1, err=1, err_code=01.
   -> div_en, ser_en and mul_en never asserted.
3. Timeout: a=1, b=c=0, div_ok held low.
   -> DONE after 32 RUN cycles, err_code=10, mul_en never high, ser_en low after T10.
4. Early divider: div_ok at T3.
   -> div_en low from T4.
   -> MUL starts at T11 after ser_done, not at T4; out_valid at T13.
5. Backpressure: out_ready low for 5 cycles after out_valid; in_valid=1 with new operands.
   -> out_valid and err stable, in_ready=0, operands unchanged.
   -> after out_ready, in_ready=1 one cycle later and the new set is accepted.
6. Reset mid-RUN: rst_n=0 at T5.
   -> all enables and out_valid drop asynchronously, in_ready=1.
   -> after release, a new transaction completes as in case 1.
